// File: rtl/prbs_pkg.sv
// Shared definitions for the 4-bit PRBS (x^4+x^3+1) generator/checker pair.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int TAP_HI   = 3;
    localparam int TAP_LO   = 2;
    localparam int PRBS_LEN = 4;

    // Next serial bit predicted from the history (hist[0] newest, hist[3] oldest).
    function automatic logic prbs_pred(input logic [PRBS_LEN-1:0] h);
        return h[TAP_HI] ^ h[TAP_LO];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear is applied before increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Clear-then-increment, holding at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= W'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prbs4_checker.sv
// Self-synchronising PRBS4 serial checker: locks onto the generator MSB stream,
// then free-runs its own prediction to count bit errors and detect loss of sync.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   SEARCH | shift received bits into hist, count qualified matches
//   LOCKED | hist free-runs on its own prediction, errors counted/windowed
module prbs4_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT  = 8,
    parameter int WINDOW      = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] LOSS_LIM   = EW'(LOSS_THRESH);

    state_t                state;
    state_t                state_nx;
    logic [PRBS_LEN-1:0]   hist;
    logic [MW-1:0]         match_cnt;
    logic [WW-1:0]         win_cnt;
    logic [EW-1:0]         win_err;

    logic                  pred;
    logic                  mism;
    logic                  qual;
    logic                  lock_hit;
    logic                  wrap;
    logic [EW-1:0]         win_err_nx;
    logic                  count_err;
    logic                  loss;

    assign pred       = prbs_pred(hist);
    assign mism       = (data_in != pred);
    // An all-zero history predicts zero forever, so it never qualifies.
    assign qual       = !mism && (hist != '0);
    assign lock_hit   = data_valid && (state == SEARCH) && qual && (match_cnt == MATCH_LAST);
    assign wrap       = (win_cnt == WIN_LAST);
    // An error on the wrapping bit opens the new window with a count of one.
    assign win_err_nx = wrap ? EW'(mism) : (win_err + EW'(mism));
    assign count_err  = data_valid && (state == LOCKED) && mism;
    assign loss       = data_valid && (state == LOCKED) && (win_err_nx >= LOSS_LIM);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: lock on the final qualified match, drop on window loss.
    always_comb begin
        state_nx = state;
        case (state)
            SEARCH: if (lock_hit) state_nx = LOCKED;
            LOCKED: if (loss)     state_nx = SEARCH;
            default:              state_nx = SEARCH;
        endcase
    end

    // Output decode.
    always_comb begin
        locked = (state == LOCKED);
    end

    // History, match and window bookkeeping; only valid bits advance anything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= count_err;
            if (data_valid) begin
                if (state == SEARCH) begin
                    hist <= {hist[PRBS_LEN-2:0], data_in};
                    if (qual && !lock_hit) begin
                        match_cnt <= match_cnt + 1'b1;
                    end else begin
                        match_cnt <= '0;
                    end
                    if (lock_hit) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end
                end else begin
                    // Free-running prediction keeps a single line error from
                    // corrupting the following bits' expectations.
                    hist    <= {hist[PRBS_LEN-2:0], pred};
                    win_cnt <= wrap ? '0 : (win_cnt + 1'b1);
                    win_err <= win_err_nx;
                    if (loss) begin
                        match_cnt <= '0;
                    end
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (count_err),
        .clr (err_clr),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: directed scenarios plus randomized traffic, all
// checked against a sequence-table reference model. A second instance with a
// 2-bit error counter shares the stimulus to exercise saturation.
module tb_prbs4_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_in = 1'b0;
    logic        data_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic        locked2;
    logic        err_pulse2;
    logic [1:0]  err_cnt2;

    prbs4_checker dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .err_clr    (err_clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt)
    );

    prbs4_checker #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .err_clr    (err_clr),
        .locked     (locked2),
        .err_pulse  (err_pulse2),
        .err_cnt    (err_cnt2)
    );

    always #5 clk = ~clk;

    // One period of the generator output from seed 0001.
    int seq [15] = '{0,0,0,1,0,0,1,1,0,1,0,1,1,1,1};
    int gp;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state.
    int m_cnt;
    bit m_locked;
    bit m_pulse;
    int mh [4];       // mh[0] oldest .. mh[3] newest
    int m_phase;
    int m_wbits;
    int m_werr;
    int m_match;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_locked = 0; m_pulse = 0;
        for (int i = 0; i < 4; i++) mh[i] = 0;
        m_phase = 0; m_wbits = 0; m_werr = 0; m_match = 0;
    endtask

    // Search: a qualified match is any nonzero 4-bit history that, extended by
    // the new bit, appears as five consecutive bits of the m-sequence.
    // Locked: the expected bit is read from the sequence table at the locked phase.
    task automatic model_step(input bit v, input int b, input bit clr);
        bit err;
        int k;
        int e;
        err = 0;
        if (v) begin
            if (!m_locked) begin
                k = -1;
                if ((mh[0] | mh[1] | mh[2] | mh[3]) != 0) begin
                    for (int s = 0; s < 15; s++) begin
                        if (seq[s] == mh[0] && seq[(s+1)%15] == mh[1] &&
                            seq[(s+2)%15] == mh[2] && seq[(s+3)%15] == mh[3] &&
                            seq[(s+4)%15] == b)
                            k = s;
                    end
                end
                mh[0] = mh[1]; mh[1] = mh[2]; mh[2] = mh[3]; mh[3] = b;
                if (k >= 0) m_match++; else m_match = 0;
                if (m_match == 8) begin
                    m_locked = 1;
                    m_phase  = (k + 5) % 15;
                    m_wbits  = 0;
                    m_werr   = 0;
                    m_match  = 0;
                end
            end else begin
                e = seq[m_phase];
                m_phase = (m_phase + 1) % 15;
                err = (b != e);
                mh[0] = mh[1]; mh[1] = mh[2]; mh[2] = mh[3]; mh[3] = e;
                if (m_wbits == 15) begin
                    m_wbits = 0;
                    m_werr  = int'(err);
                end else begin
                    m_wbits++;
                    m_werr += int'(err);
                end
                if (m_werr >= 4) begin
                    m_locked = 0;
                    m_match  = 0;
                end
            end
        end
        m_pulse = err;
        if (clr) m_cnt = int'(err);
        else     m_cnt += int'(err);
    endtask

    task automatic check_outputs();
        check_val("locked",     locked,     m_locked);
        check_val("err_pulse",  err_pulse,  m_pulse);
        check_val("err_cnt",    err_cnt,    (m_cnt > 65535) ? 65535 : m_cnt);
        check_val("locked_w2",  locked2,    m_locked);
        check_val("err_pulse_w2", err_pulse2, m_pulse);
        check_val("err_cnt_w2", err_cnt2,   (m_cnt > 3) ? 3 : m_cnt);
    endtask

    // Drive one cycle at the falling edge, then return just after the rising edge.
    task automatic step(input bit v, input bit flip, input bit clr, input bit zero);
        int b;
        @(negedge clk);
        check_outputs();
        if (!v)        b = int'($urandom_range(1, 0));
        else if (zero) b = 0;
        else           b = seq[gp] ^ int'(flip);
        if (v && !zero) gp = (gp + 1) % 15;
        data_in    = b[0];
        data_valid = v;
        err_clr    = clr;
        model_step(v, b, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; data_valid = 1'b0; err_clr = 1'b0; data_in = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b0;
        gp = 0;
    endtask

    int lock_idx;
    int pc;
    int vb;
    int zero_left;
    int flip_div;

    initial begin
        model_reset();
        gp = 0;

        // Clean stream from seed 0001: lock on bit index 11, no errors.
        do_reset();
        lock_idx = -1;
        for (int i = 0; i < 100; i++) begin
            step(1, 0, 0, 0);
            if (locked && lock_idx < 0) lock_idx = i;
        end
        check_val("lock_idx", lock_idx, 11);
        check_val("cnt_clean", err_cnt, 0);

        // Single inverted bit: one pulse right after it, none in the next 15 bits.
        step(1, 1, 0, 0);
        check_val("single_pulse", err_pulse, 1);
        pc = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 0);
            pc += int'(err_pulse);
        end
        check_val("no_extra_pulse", pc, 0);
        check_val("single_cnt", err_cnt, 1);
        check_val("single_locked", locked, 1);

        // Four errors in one window: lock drops on the fourth, then relock in 8.
        step(1, 0, 1, 0);
        for (int i = 0; i < 16 && m_wbits != 0; i++) step(1, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            step(1, 1, 0, 0);
            check_val("loss_locked", locked, (j < 3) ? 1 : 0);
        end
        check_val("loss_cnt", err_cnt, 4);
        lock_idx = -1;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            if (locked && lock_idx < 0) lock_idx = i + 1;
        end
        check_val("relock_bits", lock_idx, 8);

        // Five spaced errors: narrow counter saturates at 3; clear with error gives 1.
        step(1, 0, 1, 0);
        for (int e = 0; e < 5; e++) begin
            step(1, 1, 0, 0);
            for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        end
        check_val("sat_cnt16", err_cnt, 5);
        check_val("sat_cnt2", err_cnt2, 3);
        check_val("sat_locked", locked, 1);
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        check_val("clr_inc_cnt16", err_cnt, 1);
        check_val("clr_inc_cnt2", err_cnt2, 1);

        // Asynchronous reset while locked, sampled well before the next edge.
        #2 rst = 1'b1;
        #1;
        check_val("async_locked", locked, 0);
        check_val("async_cnt", err_cnt, 0);
        check_val("async_pulse", err_pulse, 0);
        data_valid = 1'b0; err_clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        gp = 0;

        // Constant-zero input never locks and never flags errors.
        do_reset();
        pc = 0;
        for (int i = 0; i < 50; i++) begin
            step(1, 0, 0, 1);
            pc += int'(err_pulse);
        end
        check_val("zero_pulses", pc, 0);
        check_val("zero_locked", locked, 0);
        check_val("zero_cnt", err_cnt, 0);

        // Valid every other cycle: lock still after 12 valid bits.
        do_reset();
        vb = 0;
        lock_idx = -1;
        for (int i = 0; i < 60; i++) begin
            step(i % 2 == 0, 0, 0, 0);
            if (i % 2 == 0) vb++;
            if (locked && lock_idx < 0) lock_idx = vb;
        end
        check_val("gapped_lock_bits", lock_idx, 12);

        // Randomized traffic: gaps, errors at varying density, clears, zero bursts.
        do_reset();
        gp = int'($urandom_range(14, 0));
        zero_left = 0;
        flip_div = 40;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) flip_div = ($urandom_range(3, 0) == 0) ? 3 : 40;
            if (zero_left == 0 && $urandom_range(299, 0) == 0) zero_left = int'($urandom_range(20, 5));
            step($urandom_range(9, 0) < 8,
                 $urandom_range(flip_div - 1, 0) == 0,
                 $urandom_range(59, 0) == 0,
                 zero_left > 0);
            if (zero_left > 0) zero_left--;
        end
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
